// File: rtl/stats_counter_ram.sv
// stats_counter_ram
//   Statistics counter store. Accumulates an AXI-stream of increments
//   (tdata = increment, tid = counter index) into wide counters held in a
//   single-port RAM. It also serves a host read port with optional
//   clear-on-read. One read-modify-write engine is shared by both sources,
//   and round-robin arbitration decides which source goes next.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   s_axis_stat_*         increment stream (tdata, tid, tvalid / tready)
//   rd_req_*              host read request (addr, clear, valid / ready)
//   rd_resp_data/valid    single-cycle response strobe, no backpressure
//
// Each op takes two cycles:
//   READ  - arbitrate, latch the granted op, and read the RAM.
//   WRITE - write back the updated value; read ops also emit the response.
// After reset, INIT walks every address and writes zero to it.
module stats_counter_ram #(
  parameter int STAT_INC_WIDTH   = 16,
  parameter int STAT_ID_WIDTH    = 5,
  parameter int STAT_COUNT_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [STAT_INC_WIDTH-1:0]   s_axis_stat_tdata,
  input  logic [STAT_ID_WIDTH-1:0]    s_axis_stat_tid,
  input  logic                        s_axis_stat_tvalid,
  output logic                        s_axis_stat_tready,
  input  logic [STAT_ID_WIDTH-1:0]    rd_req_addr,
  input  logic                        rd_req_clear,
  input  logic                        rd_req_valid,
  output logic                        rd_req_ready,
  output logic [STAT_COUNT_WIDTH-1:0] rd_resp_data,
  output logic                        rd_resp_valid
);

  localparam int DEPTH = 2**STAT_ID_WIDTH;

  localparam logic [1:0] S_INIT  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;

  localparam logic GRANT_STREAM = 1'b0;
  localparam logic GRANT_READ   = 1'b1;

  logic [1:0]                  state;
  logic [STAT_ID_WIDTH-1:0]    init_ptr;
  logic                        last_grant;

  // latched op
  logic                        op_is_rd;
  logic                        op_clr;
  logic [STAT_ID_WIDTH-1:0]    op_addr;
  logic [STAT_INC_WIDTH-1:0]   op_inc;

  logic [STAT_COUNT_WIDTH-1:0] mem [DEPTH];
  logic [STAT_COUNT_WIDTH-1:0] old_q;

  logic                        grant_rd, grant_st;
  logic [STAT_ID_WIDTH-1:0]    rd_addr_sel;
  logic                        ram_we;
  logic [STAT_ID_WIDTH-1:0]    ram_waddr;
  logic [STAT_COUNT_WIDTH-1:0] wr_data;

  // The read port wins when it is the only one asking, or when both ask and
  // the stream had the previous grant.
  always_comb begin
    grant_rd = 1'b0;
    grant_st = 1'b0;
    if (state == S_READ) begin
      grant_rd = rd_req_valid && (!s_axis_stat_tvalid || last_grant == GRANT_STREAM);
      grant_st = s_axis_stat_tvalid && !grant_rd;
    end
  end

  assign rd_req_ready       = grant_rd;
  assign s_axis_stat_tready = grant_st;
  assign rd_addr_sel        = grant_rd ? rd_req_addr : s_axis_stat_tid;

  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = op_addr;
    wr_data   = '0;
    if (state == S_INIT) begin
      ram_we    = 1'b1;
      ram_waddr = init_ptr;
    end else if (state == S_WRITE) begin
      ram_we = 1'b1;
      if (op_is_rd) wr_data = op_clr ? '0 : old_q;
      else          wr_data = old_q + STAT_COUNT_WIDTH'(op_inc); // silent wrap
    end
  end

  // RAM array without reset. While rst_n is held low the state sits in INIT
  // and rewrites address 0 with zero. This is harmless, because a full INIT
  // pass follows the release of reset anyway.
  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= wr_data;
    if (grant_rd || grant_st) old_q <= mem[rd_addr_sel];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_INIT;
      init_ptr      <= '0;
      last_grant    <= GRANT_STREAM;
      op_is_rd      <= 1'b0;
      op_clr        <= 1'b0;
      op_addr       <= '0;
      op_inc        <= '0;
      rd_resp_data  <= '0;
      rd_resp_valid <= 1'b0;
    end else begin
      rd_resp_valid <= 1'b0;
      case (state)
        S_INIT: begin
          init_ptr <= init_ptr + 1'b1;
          if (&init_ptr) state <= S_READ;
        end
        S_READ: begin
          if (grant_rd || grant_st) begin
            op_is_rd   <= grant_rd;
            op_clr     <= rd_req_clear;
            op_addr    <= rd_addr_sel;
            op_inc     <= s_axis_stat_tdata;
            last_grant <= grant_rd ? GRANT_READ : GRANT_STREAM;
            state      <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (op_is_rd) begin
            rd_resp_data  <= old_q;
            rd_resp_valid <= 1'b1;
          end
          state <= S_READ;
        end
        default: state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_stats_counter_ram.sv
// Directed bench for stats_counter_ram.
// Instance u_dut uses the default widths (16/5/32).
// Instance u_w uses a 16-bit counter so that wrap-around can be exercised.
module tb_stats_counter_ram;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic [15:0] s_tdata = '0;
  logic [4:0]  s_tid = '0;
  logic        s_tvalid = 1'b0, s_tready;
  logic [4:0]  rd_addr = '0;
  logic        rd_clr = 1'b0, rd_valid = 1'b0, rd_ready;
  logic [31:0] resp_data;
  logic        resp_valid;

  logic [15:0] w_tdata = '0;
  logic [4:0]  w_tid = '0;
  logic        w_tvalid = 1'b0, w_tready;
  logic [4:0]  w_addr = '0;
  logic        w_clr = 1'b0, w_valid = 1'b0, w_ready;
  logic [15:0] w_resp_data;
  logic        w_resp_valid;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  stats_counter_ram u_dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_stat_tdata(s_tdata), .s_axis_stat_tid(s_tid),
    .s_axis_stat_tvalid(s_tvalid), .s_axis_stat_tready(s_tready),
    .rd_req_addr(rd_addr), .rd_req_clear(rd_clr),
    .rd_req_valid(rd_valid), .rd_req_ready(rd_ready),
    .rd_resp_data(resp_data), .rd_resp_valid(resp_valid)
  );

  stats_counter_ram #(.STAT_INC_WIDTH(16), .STAT_ID_WIDTH(5), .STAT_COUNT_WIDTH(16)) u_w (
    .clk(clk), .rst_n(rst_n),
    .s_axis_stat_tdata(w_tdata), .s_axis_stat_tid(w_tid),
    .s_axis_stat_tvalid(w_tvalid), .s_axis_stat_tready(w_tready),
    .rd_req_addr(w_addr), .rd_req_clear(w_clr),
    .rd_req_valid(w_valid), .rd_req_ready(w_ready),
    .rd_resp_data(w_resp_data), .rd_resp_valid(w_resp_valid)
  );

  typedef struct {
    bit          is_rd;
    int          id;
    int          val;
    bit          clr;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // Called at (or just after) a negedge. Returns one cycle after acceptance.
  task automatic do_inc(input bit w, input int id, input int val);
    bit ok = 1'b0;
    if (w) begin w_tid = 5'(id); w_tdata = 16'(val); w_tvalid = 1'b1; end
    else   begin s_tid = 5'(id); s_tdata = 16'(val); s_tvalid = 1'b1; end
    for (int k = 0; k < 20 && !ok; k++) begin
      #1;
      ok = w ? w_tready : s_tready;
      @(negedge clk);
    end
    w_tvalid = 1'b0;
    s_tvalid = 1'b0;
    if (!ok) chk("inc_accept_timeout", 32'd0, 32'd1);
  endtask

  // Issues a read and checks that the response strobe arrives two cycles
  // after acceptance. Returns at the response cycle (state READ).
  task automatic do_rd(input bit w, input int a, input bit clr, output logic [31:0] d);
    bit   ok = 1'b0;
    logic v1, v2;
    d = 'x;
    if (w) begin w_addr = 5'(a); w_clr = clr; w_valid = 1'b1; end
    else   begin rd_addr = 5'(a); rd_clr = clr; rd_valid = 1'b1; end
    for (int k = 0; k < 20 && !ok; k++) begin
      #1;
      ok = w ? w_ready : rd_ready;
      @(negedge clk);
    end
    w_valid  = 1'b0;
    rd_valid = 1'b0;
    if (!ok) begin
      chk("rd_accept_timeout", 32'd0, 32'd1);
    end else begin
      #1 v1 = w ? w_resp_valid : resp_valid;
      @(negedge clk);
      #1 v2 = w ? w_resp_valid : resp_valid;
      d = w ? {16'h0, w_resp_data} : resp_data;
      chk("rd_latency", {30'd0, v1, v2}, 32'd1);
    end
  endtask

  // Releases reset with both sources requesting. Both readies must stay low
  // for 32 cycles, and then the read port must be granted.
  task automatic wait_init();
    int hi = 0;
    rd_addr  = '0;
    rd_valid = 1'b1;
    s_tvalid = 1'b1;
    rst_n    = 1'b1;
    for (int k = 0; k < 32; k++) begin
      #1;
      if (rd_ready || s_tready) hi++;
      @(negedge clk);
    end
    chk("init_readies_low", 32'(hi), 32'd0);
    #1 chk("init_done_grant", {31'd0, rd_ready}, 32'd1);
    rd_valid = 1'b0;
    s_tvalid = 1'b0;
  endtask

  task automatic read_all_zero(input string nm);
    logic [31:0] d;
    int nz = 0;
    for (int a = 0; a < 32; a++) begin
      do_rd(1'b0, a, 1'b0, d);
      if (d !== 32'd0) nz++;
    end
    chk(nm, 32'(nz), 32'd0);
  endtask

  initial begin
    logic [31:0] d;

    tbl[0]  = '{0, 3, 100,   0, 0};
    tbl[1]  = '{0, 3, 100,   0, 0};
    tbl[2]  = '{1, 3, 0,     0, 32'd200};
    tbl[3]  = '{1, 4, 0,     0, 32'd0};
    tbl[4]  = '{0, 2, 55,    0, 0};
    tbl[5]  = '{1, 2, 0,     1, 32'd55};
    tbl[6]  = '{1, 2, 0,     0, 32'd0};
    tbl[7]  = '{0, 2, 1,     0, 0};
    tbl[8]  = '{1, 2, 0,     0, 32'd1};
    tbl[9]  = '{0, 5, 0,     0, 0};
    tbl[10] = '{1, 5, 0,     0, 32'd0};
    tbl[11] = '{0, 6, 65535, 0, 0};
    tbl[12] = '{0, 6, 65535, 0, 0};
    tbl[13] = '{1, 6, 0,     0, 32'h0001_FFFE};

    // reset values
    #3;
    chk("rst_tready",     {31'd0, s_tready},   32'd0);
    chk("rst_rd_ready",   {31'd0, rd_ready},   32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_data",  resp_data,           32'd0);
    @(negedge clk);
    @(negedge clk);

    wait_init();
    read_all_zero("init_all_zero");

    // wrap on the 16-bit instance
    do_inc(1'b1, 7, 16'hFFFF);
    do_inc(1'b1, 7, 16'h0002);
    do_rd(1'b1, 7, 1'b0, d);
    chk("wrap_16", d, 32'h0001);
    do_rd(1'b1, 8, 1'b0, d);
    chk("wrap_neighbour", d, 32'h0000);

    for (int i = 0; i < 14; i++) begin
      if (tbl[i].is_rd) begin
        do_rd(1'b0, tbl[i].id, tbl[i].clr, d);
        chk($sformatf("tbl%0d_rd%0d", i, tbl[i].id), d, tbl[i].exp);
      end else begin
        do_inc(1'b0, tbl[i].id, tbl[i].val);
      end
    end

    // reset during the WRITE cycle of a read op
    do_inc(1'b0, 9, 7);
    rd_addr  = 5'd9;
    rd_clr   = 1'b0;
    rd_valid = 1'b1;
    begin
      bit ok = 1'b0;
      for (int k = 0; k < 20 && !ok; k++) begin
        #1 ok = rd_ready;
        @(negedge clk);
      end
      chk("midrst_accept", {31'd0, ok}, 32'd1);
    end
    rd_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("midrst_resp0",  {31'd0, resp_valid}, 32'd0);
    chk("midrst_ready",  {30'd0, rd_ready, s_tready}, 32'd0);
    @(negedge clk);
    #1 chk("midrst_resp1", {31'd0, resp_valid}, 32'd0);
    chk("midrst_data",   resp_data, 32'd0);
    wait_init();
    read_all_zero("reinit_all_zero");

    // contention: a fresh reset leaves last_grant = stream, so the read goes first
    rst_n = 1'b0;
    @(negedge clk);
    wait_init();
    s_tid = 5'd1; s_tdata = 16'd1; s_tvalid = 1'b1;
    rd_addr = 5'd1; rd_clr = 1'b0; rd_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1;
      chk($sformatf("cont_rd_ready%0d", i), {31'd0, rd_ready}, {31'd0, i % 4 == 0});
      chk($sformatf("cont_tready%0d", i),   {31'd0, s_tready}, {31'd0, i % 4 == 2});
      if (i % 4 == 2) begin
        chk($sformatf("cont_resp_v%0d", i), {31'd0, resp_valid}, 32'd1);
        chk($sformatf("cont_resp_d%0d", i), resp_data, 32'(i / 4));
      end else begin
        chk($sformatf("cont_resp_v%0d", i), {31'd0, resp_valid}, 32'd0);
      end
      @(negedge clk);
    end
    s_tvalid = 1'b0;
    rd_valid = 1'b0;
    do_rd(1'b0, 1, 1'b0, d);
    chk("cont_final", d, 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout got=running want=done");
    $fatal(1);
  end

endmodule
